mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  MEM->WB pipeline register and load-alignment unit. It sits directly upstream of
//  the GPR file and drives its write port (rd_addr, rd_in, rd_byte_w_en, write).
//  It also extracts and sign- or zero-extends load data by byte offset, flags misaligned
//  loads, and gives the ID-stage forwarding unit a bypass view of the pending write.
// PARAMETERS
//  DATA_WIDTH  32  datapath width; only 32 is supported
//  ADDR_WIDTH  5   GPR index width
// PORTS
//  clk            in   1   clock; the stage captures on posedge (GPR writes on negedge)
//  reset          in   1   synchronous reset, active-high
//  mem_valid      in   1   MEM slot holds a live instruction
//  mem_reg_write  in   1   instruction writes a GPR
//  mem_rd_addr    in   5   destination GPR
//  mem_ld_type    in   3   000 ALU, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 110 LWL, 111 LWR
//  mem_byte_off   in   2   effective address [1:0]
//  mem_alu_res    in   32  ALU result, used when ld_type=000
//  mem_rdata      in   32  aligned data-memory word, little-endian (byte0 = [7:0])
//  stall          in   1   hold the stage contents
//  flush          in   1   kill the incoming instruction
//  wb_rd_addr     out  5   to GPR rd_addr
//  wb_rd_in       out  32  to GPR rd_in, already positioned in byte lanes
//  wb_byte_w_en   out  4   to GPR rd_byte_w_en
//  wb_write       out  1   to GPR write
//  wb_addr_err    out  1   one-cycle pulse: misaligned load, write suppressed
//  fwd_valid      out  1   bypass info valid (wb_write & wb_rd_addr!=0)
// BEHAVIOUR
//  - Reset: every output is 0, held-instruction valid flag is 0, done flag is 0.
//  - Priority: reset > flush > stall > capture. Latency: inputs appear on wb_* 1 cycle later.
//  - Capture (no stall): register the inputs and compute the following.
//    - ALU (000): data=alu_res, en=1111.
//    - LB/LBU: byte=rdata[8*off+:8]; sign- or zero-extend to 32; en=1111.
//    - LH/LHU: half=rdata[16*off[1]+:16]; extend; en=1111. If off[0]=1, this is misaligned.
//    - LW: data=rdata, en=1111. If off!=0, this is misaligned.
//    - LWL, off=k: en bytes [3:3-k] set; data=rdata<<(8*(3-k)).
//      off 0..3 gives en 1000/1100/1110/1111.
//    - LWR, off=k: en bytes [3-k:0] set; data=rdata>>(8*k).
//      off 0..3 gives en 1111/0111/0011/0001.
//  - wb_write = valid & reg_write & !misaligned & rd_addr!=0 & !done.
//  - Misaligned load: write and en are forced to 0; wb_addr_err=1 for exactly one cycle.
//  - Stall: all registers hold. On the first stalled cycle, done is set so that
//    wb_write/wb_addr_err drop after one cycle. The GPR is never written twice
//    for one instruction. done is cleared on the next capture.
//  - Flush: next cycle valid=0, wb_write=0, en=0, wb_addr_err=0. Flush overrides a
//    simultaneous stall.
//  - Reset mid-stall or mid-flush: every output is 0 on the next edge; no pending write survives.
//  - rd_addr=0: data is still computed, but wb_write=0.
// CONFIGURATION
//  - WB_LWLR_EN defined: LWL/LWR are handled as above.
//  - WB_LWLR_EN undefined: ld_type 110/111 is treated as a no-op, with wb_write=0, en=0
//    and wb_addr_err=0. The lane-merge logic is not synthesised.
// TESTING
//  1. ALU, rd=5, alu_res=32'h1234_5678 -> next cycle: rd_in=32'h1234_5678, en=1111, write=1.
//  2. LB off=2, rdata=32'h00_80_00_00 -> rd_in=32'hFFFF_FF80.
//     LBU with the same inputs -> rd_in=32'h0000_0080.
//  3. LH off=1 -> write=0, wb_addr_err=1 for 1 cycle.
//     LW off=0, rdata=32'hDEAD_BEEF -> rd_in=32'hDEAD_BEEF, write=1.
//  4. Capture a write, then hold stall=1 for 3 cycles -> write=1 on the first cycle only,
//     0 on the next two; outputs are held.
//  5. flush=1 and stall=1 together -> next cycle write=0.
//     reset=1 during a stall -> all outputs 0.
//  6. (WB_LWLR_EN) LWL off=1, rdata=32'hAABB_CCDD -> en=1100, rd_in[31:16]=16'hCCDD.
//     LWR off=3 -> en=0001, rd_in[7:0]=8'hAA. Without the macro, both give write=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with load alignment/extension, misalignment detection and GPR bypass view.
// Optional feature macro: WB_LWLR_EN enables LWL/LWR lane merging; without it ld_type 110/111 is a no-op.
module mem_wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [2:0]            mem_ld_type,
    input  logic [1:0]            mem_byte_off,
    input  logic [DATA_WIDTH-1:0] mem_alu_res,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  stall,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] wb_rd_addr,
    output logic [DATA_WIDTH-1:0] wb_rd_in,
    output logic [3:0]            wb_byte_w_en,
    output logic                  wb_write,
    output logic                  wb_addr_err,
    output logic                  fwd_valid
);

    localparam logic [2:0] LD_ALU = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;
    localparam logic [2:0] LD_LW  = 3'b101;
    localparam logic [2:0] LD_LWL = 3'b110;
    localparam logic [2:0] LD_LWR = 3'b111;

    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic [3:0]            nxt_en;
    logic                  nxt_mis;
    logic                  nxt_noop;

    logic                  valid_q;
    logic                  reg_write_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            en_q;
    logic                  mis_q;
    logic                  noop_q;
    logic                  done_q;

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (mem_byte_off)
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = mem_byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        nxt_data = mem_alu_res;
        nxt_en   = 4'hF;
        nxt_mis  = 1'b0;
        nxt_noop = 1'b0;
        case (mem_ld_type)
            LD_ALU: nxt_data = mem_alu_res;
            LD_LB:  nxt_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            LD_LBU: nxt_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            LD_LH: begin
                nxt_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
                nxt_mis  = mem_byte_off[0];
            end
            LD_LHU: begin
                nxt_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
                nxt_mis  = mem_byte_off[0];
            end
            LD_LW: begin
                nxt_data = mem_rdata;
                nxt_mis  = (mem_byte_off != 2'd0);
            end
`ifdef WB_LWLR_EN
            // LWL fills the upper lanes, LWR the lower lanes; the GPR merges by byte enable.
            LD_LWL: begin
                nxt_data = mem_rdata << {2'd3 - mem_byte_off, 3'b000};
                nxt_en   = 4'hF << (2'd3 - mem_byte_off);
            end
            LD_LWR: begin
                nxt_data = mem_rdata >> {mem_byte_off, 3'b000};
                nxt_en   = 4'hF >> mem_byte_off;
            end
`else
            LD_LWL, LD_LWR: begin
                nxt_data = '0;
                nxt_noop = 1'b1;
            end
`endif
            default: nxt_data = mem_alu_res;
        endcase
        if (!mem_valid || nxt_mis || nxt_noop) nxt_en = 4'h0;
    end

    // done marks a held instruction whose write/error has already been presented once.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_addr_q   <= '0;
            data_q      <= '0;
            en_q        <= 4'h0;
            mis_q       <= 1'b0;
            noop_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (stall) begin
            done_q <= 1'b1;
        end else begin
            valid_q     <= mem_valid;
            reg_write_q <= mem_reg_write;
            rd_addr_q   <= mem_rd_addr;
            data_q      <= nxt_data;
            en_q        <= nxt_en;
            mis_q       <= nxt_mis;
            noop_q      <= nxt_noop;
            done_q      <= 1'b0;
        end
    end

    assign wb_rd_addr   = rd_addr_q;
    assign wb_rd_in     = data_q;
    assign wb_byte_w_en = en_q;
    assign wb_write     = valid_q & reg_write_q & ~mis_q & ~noop_q &
                          (rd_addr_q != '0) & ~done_q;
    assign wb_addr_err  = valid_q & mis_q & ~done_q;
    assign fwd_valid    = wb_write;

endmodule
